// File: rtl/spi_scene_loader_pkg.sv
// spi_scene_loader_pkg: shared defaults, command layout, FSM encoding and record sizing
package spi_scene_loader_pkg;
  localparam int N_POLY_DEF = 4;
  localparam int WPX_DEF = 8;
  localparam int WPY_DEF = 7;
  localparam int WCOLOR_DEF = 6;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ADDR_W = 7;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DROP} state_t;
  function automatic int rec_width(input int wpx, input int wpy, input int wcolor);
    return 1 + wcolor + 3 * (wpx + wpy);
  endfunction
  function automatic int rec_bytes(input int recw);
    return (recw + 7) / 8;
  endfunction
endpackage

// File: rtl/spi_scene_loader_if.sv
// spi_scene_loader_if: SPI pins between a host (master) and the scene loader (slave)
interface spi_scene_loader_if;
  logic cs_in;
  logic sck_in;
  logic mosi_in;
  logic miso_out;
  modport master(output cs_in, output sck_in, output mosi_in, input miso_out);
  modport slave(input cs_in, input sck_in, input mosi_in, output miso_out);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronisers for cs/sck/mosi plus sck and cs edge strobes
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_i,
  input  logic sck_i,
  input  logic mosi_i,
  output logic cs_o,
  output logic mosi_o,
  output logic cs_rise_o,
  output logic cs_fall_o,
  output logic sck_rise_o,
  output logic sck_fall_o
);
  logic [2:0] cs_q, sck_q;
  logic [1:0] mosi_q;
  // cs resets low so a frame only arms after cs has been seen high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q <= '0;
      sck_q <= '0;
      mosi_q <= '0;
    end else begin
      cs_q <= {cs_q[1:0], cs_i};
      sck_q <= {sck_q[1:0], sck_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end
  assign cs_o = cs_q[1];
  assign mosi_o = mosi_q[1];
  assign cs_rise_o = cs_q[1] & ~cs_q[2];
  assign cs_fall_o = ~cs_q[1] & cs_q[2];
  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
endmodule

// File: rtl/spi_scene_loader.sv
// spi_scene_loader: SPI-written shadow scene registers, copied to live outputs on en_load.
// Define SPI_READBACK_EN to shift shadow contents out on miso_out for read commands.
module spi_scene_loader
  import spi_scene_loader_pkg::*;
#(
  parameter int N_POLY = N_POLY_DEF,
  parameter int WPX = WPX_DEF,
  parameter int WPY = WPY_DEF,
  parameter int WCOLOR = WCOLOR_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  spi_scene_loader_if.slave        spi,
  input  logic                     en_load,
  output logic [WCOLOR-1:0]        bg_color_out,
  output logic [WCOLOR*N_POLY-1:0] poly_color_out,
  output logic [WPX*N_POLY-1:0]    v0_x_out,
  output logic [WPX*N_POLY-1:0]    v1_x_out,
  output logic [WPX*N_POLY-1:0]    v2_x_out,
  output logic [WPY*N_POLY-1:0]    v0_y_out,
  output logic [WPY*N_POLY-1:0]    v1_y_out,
  output logic [WPY*N_POLY-1:0]    v2_y_out,
  output logic [N_POLY-1:0]        poly_enable_out,
  output logic                     commit_out
);
  localparam int RECW = rec_width(WPX, WPY, WCOLOR);
  localparam int UW = 8 * rec_bytes(RECW);
  localparam int CW = $clog2(UW);
  localparam logic [CMD_ADDR_W-1:0] NP = CMD_ADDR_W'(N_POLY);
`ifdef SPI_READBACK_EN
  localparam bit RD_EN = 1'b1;
  logic sck_fall;
`else
  localparam bit RD_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RECW-2:0] sr_q;
  logic [RECW-1:0] word;
  logic [CMD_ADDR_W-1:0] addr_q, addr_d;
  logic rw_q, rw_d, pend_q, pend_d, commit_q, commit, last, shifting;
  logic cs_s, mosi_s, cs_rise, cs_fall, sck_rise;
  logic [WCOLOR-1:0] bg_sh_q, bg_sh_d, bg_q;
  logic [RECW-1:0] rec_sh_q [N_POLY];
  logic [RECW-1:0] rec_sh_d [N_POLY];
  logic [RECW-1:0] rec_q [N_POLY];
  spi_sync_edge u_sync (
    .clk, .rst_n,
    .cs_i(spi.cs_in), .sck_i(spi.sck_in), .mosi_i(spi.mosi_in),
    .cs_o(cs_s), .mosi_o(mosi_s), .cs_rise_o(cs_rise), .cs_fall_o(cs_fall), .sck_rise_o(sck_rise),
`ifdef SPI_READBACK_EN
    .sck_fall_o(sck_fall)
`else
    .sck_fall_o()
`endif
  );
  // padding bits above RECW shift out of the top and are discarded
  assign word = {sr_q, mosi_s};
  assign shifting = sck_rise && (state_q == CMD || state_q == DATA);
  assign last = cnt_q == ((state_q == CMD || addr_q == '0) ? CW'(7) : CW'(UW - 1));
  assign commit = (en_load | pend_q) & cs_s;
  assign pend_d = (pend_q | en_load) & ~commit;
  always_comb begin
    state_d = state_q;
    cnt_d = shifting ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    addr_d = addr_q;
    rw_d = rw_q;
    bg_sh_d = bg_sh_q;
    rec_sh_d = rec_sh_q;
    case (state_q)
      IDLE: if (cs_fall) begin
        state_d = CMD;
        cnt_d = '0;
      end
      CMD: if (shifting && last) begin
        rw_d = word[CMD_RW_BIT];
        addr_d = word[CMD_ADDR_W-1:0];
        state_d = (word[CMD_ADDR_W-1:0] <= NP && (word[CMD_RW_BIT] || RD_EN)) ? DATA : DROP;
      end
      DATA: if (shifting && last) begin
        if (rw_q && addr_q == '0) bg_sh_d = word[WCOLOR-1:0];
        for (int p = 0; p < N_POLY; p++)
          if (rw_q && addr_q == CMD_ADDR_W'(p + 1)) rec_sh_d[p] = word;
        addr_d = addr_q + 1'b1;
        state_d = (addr_q == NP) ? DROP : DATA;
      end
      default: ;
    endcase
    if (cs_rise) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      addr_q <= '0;
      rw_q <= 1'b0;
      pend_q <= 1'b0;
      commit_q <= 1'b0;
      bg_sh_q <= '0;
      bg_q <= '0;
      for (int p = 0; p < N_POLY; p++) begin
        rec_sh_q[p] <= '0;
        rec_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (shifting) sr_q <= word[RECW-2:0];
      addr_q <= addr_d;
      rw_q <= rw_d;
      pend_q <= pend_d;
      commit_q <= commit;
      bg_sh_q <= bg_sh_d;
      rec_sh_q <= rec_sh_d;
      // copy next-state shadows so a same-cycle write is included
      if (commit) begin
        bg_q <= bg_sh_d;
        rec_q <= rec_sh_d;
      end
    end
  end
  assign bg_color_out = bg_q;
  assign commit_out = commit_q;
  for (genvar i = 0; i < N_POLY; i++) begin : g_poly
    assign poly_enable_out[i] = rec_q[i][RECW-1];
    assign poly_color_out[i*WCOLOR +: WCOLOR] = rec_q[i][3*(WPX+WPY) +: WCOLOR];
    assign v0_x_out[i*WPX +: WPX] = rec_q[i][3*WPY+2*WPX +: WPX];
    assign v0_y_out[i*WPY +: WPY] = rec_q[i][2*WPY+2*WPX +: WPY];
    assign v1_x_out[i*WPX +: WPX] = rec_q[i][2*WPY+WPX +: WPX];
    assign v1_y_out[i*WPY +: WPY] = rec_q[i][WPY+WPX +: WPY];
    assign v2_x_out[i*WPX +: WPX] = rec_q[i][WPY +: WPX];
    assign v2_y_out[i*WPY +: WPY] = rec_q[i][0 +: WPY];
  end
`ifdef SPI_READBACK_EN
  logic [UW-1:0] tx_q, rd_word;
  logic [CMD_ADDR_W-1:0] rd_addr;
  logic miso_q;
  // next unit to send: the command's address, or the following one at a unit boundary
  always_comb begin
    rd_addr = (state_q == CMD) ? word[CMD_ADDR_W-1:0] : addr_q + 1'b1;
    rd_word = '0;
    if (rd_addr == '0) rd_word[UW-1 -: 8] = 8'(bg_sh_q);
    for (int p = 0; p < N_POLY; p++)
      if (rd_addr == CMD_ADDR_W'(p + 1)) rd_word = UW'(rec_sh_q[p]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      miso_q <= 1'b0;
    end else if (shifting && last) tx_q <= rd_word;
    else if (sck_fall && state_q == DATA) begin
      miso_q <= tx_q[UW-1];
      tx_q <= tx_q << 1;
    end else if (state_q != DATA) miso_q <= 1'b0;
  end
  assign spi.miso_out = miso_q & ~rw_q & (state_q == DATA) & ~cs_s;
`else
  assign spi.miso_out = 1'b0;
`endif
endmodule
